// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants and state type for the line-to-beat memory bridge
package mem_bus_pkg;
  localparam int ADDR_W  = 28;
  localparam int LINE_W  = 256;
  localparam int BEAT_W  = 32;
  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int OFF_W   = $clog2(BEATS);
  localparam int LADDR_W = ADDR_W - OFF_W;
  localparam int TIMEOUT = 255;
  localparam int TMR_W   = 8;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
endpackage

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - per-beat wait counter with limit compare
module beat_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q;

  // Count consecutive no-ack cycles; clear wins over increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High when the current cycle would be the LIMIT-th miss of this beat.
  assign expired_o = (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/mem_line_bridge.sv
// rtl/mem_line_bridge.sv - serializes a cache line request into req/ack word beats
module mem_line_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = mem_bus_pkg::ADDR_W,
  parameter int LINE_W  = mem_bus_pkg::LINE_W,
  parameter int BEAT_W  = mem_bus_pkg::BEAT_W,
  parameter int TIMEOUT = mem_bus_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wr,
  output logic [LINE_W-1:0] mem_rd,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [BEAT_W-1:0] ext_wdata,
  input  logic              ext_ack,
  input  logic [BEAT_W-1:0] ext_rdata
);
  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int K_W    = $clog2(NBEATS);
  localparam logic [K_W-1:0] K_LAST = K_W'(NBEATS - 1);

  state_t                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic                  rw_q, rw_d;
  logic                  err_q, err_d;
  logic [ADDR_W-K_W-1:0] laddr_q, laddr_d;
  logic [LINE_W-1:0]     wr_buf_q;
  logic [LINE_W-1:0]     rd_buf_q;
  logic                  cap_wr;
  logic                  rd_we;
  logic                  tmr_clr;
  logic                  tmr_inc;
  logic                  tmr_expired;
  logic                  addr_off_unused;

  // Word offset within the line is implied by the beat counter.
  assign addr_off_unused = ^mem_addr[K_W-1:0];

  beat_timer #(
    .W     (TMR_W),
    .LIMIT (TIMEOUT)
  ) u_beat_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  // Control state: FSM, beat index, captured direction/address, abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      laddr_q <= laddr_d;
    end
  end

  // Next-state logic: capture in IDLE, step beats on ack, abort on timer expiry.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rw_d    = rw_q;
    err_d   = err_q;
    laddr_d = laddr_q;
    cap_wr  = 1'b0;
    rd_we   = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (mem_valid) begin
          state_d = BEAT;
          k_d     = '0;
          rw_d    = mem_rw;
          err_d   = 1'b0;
          laddr_d = mem_addr[ADDR_W-1:K_W];
          cap_wr  = mem_rw;
        end
      end
      BEAT: begin
        if (ext_ack) begin
          tmr_clr = 1'b1;
          rd_we   = ~rw_q;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line buffers: private write copy, and read line assembled beat by beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_buf_q <= '0;
      rd_buf_q <= '0;
    end else begin
      if (cap_wr) begin
        wr_buf_q <= mem_wr;
      end
      if (rd_we) begin
        rd_buf_q[k_q*BEAT_W +: BEAT_W] <= ext_rdata;
      end
    end
  end

  assign ext_req   = (state_q == BEAT);
  assign ext_we    = rw_q & (state_q == BEAT);
  assign ext_addr  = {laddr_q, k_q};
  assign ext_wdata = wr_buf_q[k_q*BEAT_W +: BEAT_W];
  assign mem_ready = (state_q == DONE);
  assign mem_err   = err_q & (state_q == DONE);
  assign mem_rd    = rd_buf_q;
endmodule

// File: tb/tb_mem_line_bridge.sv
// tb/tb_mem_line_bridge.sv - randomized self-checking bench for mem_line_bridge
module tb_mem_line_bridge;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_valid = 1'b0;
  logic         mem_rw = 1'b0;
  logic [27:0]  mem_addr = '0;
  logic [255:0] mem_wr = '0;
  logic [255:0] mem_rd;
  logic         mem_ready;
  logic         mem_err;
  logic         ext_req;
  logic         ext_we;
  logic [27:0]  ext_addr;
  logic [31:0]  ext_wdata;
  logic         ext_ack = 1'b0;
  logic [31:0]  ext_rdata = '0;

  int           checks = 0;
  int           failures = 0;
  int           wt[8];
  logic [31:0]  rdat[8];
  logic [255:0] exp_rd = '0;

  mem_line_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic set_waits(input int lo, input int hi);
    for (int i = 0; i < 8; i++) begin
      wt[i]   = $urandom_range(hi, lo);
      rdat[i] = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (ext_req !== 1'b0 || mem_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet req=%b ready=%b required 0 0", ext_req, mem_ready);
      end
      checks++;
      if (mem_rd !== exp_rd) begin
        failures++;
        $display("FAIL idle_mem_rd_held got=%h required=%h", mem_rd, exp_rd);
      end
      mem_valid = 1'b0;
      ext_ack   = 1'($urandom_range(1, 0));
      ext_rdata = $urandom;
    end
  endtask

  // Each beat b lasts wt[b]+1 cycles; a beat with 255 or more misses aborts
  // after exactly 255 cycles and mem_ready follows one cycle later.
  task automatic run_txn(input logic rw, input logic [27:0] addr,
                         input logic [255:0] wline, input logic scramble);
    int          bstart[8];
    int          abort_beat;
    int          ready_c;
    int          s;
    int          j;
    logic [27:0] ea;
    abort_beat = -1;
    s = 1;
    for (int b = 0; b < 8; b++) begin
      bstart[b] = s;
      if (wt[b] >= 255) begin
        abort_beat = b;
        break;
      end
      s += wt[b] + 1;
    end
    ready_c = (abort_beat >= 0) ? s + 255 : s;

    @(negedge clk);
    checks++;
    if (ext_req !== 1'b0 || mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_idle req=%b ready=%b required 0 0", ext_req, mem_ready);
    end
    mem_valid = 1'b1;
    mem_rw    = rw;
    mem_addr  = addr;
    mem_wr    = wline;
    ext_ack   = 1'($urandom_range(1, 0));
    ext_rdata = $urandom;
    j = 0;
    for (int c = 1; c <= ready_c; c++) begin
      @(negedge clk);
      if (scramble) begin
        mem_wr   = rand_line();
        mem_addr = $urandom;
      end
      ext_ack   = 1'b0;
      ext_rdata = $urandom;
      if (c < ready_c) begin
        if (j != abort_beat && c > bstart[j] + wt[j]) j++;
        ea = {addr[27:3], 3'(j)};
        checks++;
        if (ext_req !== 1'b1 || mem_ready !== 1'b0) begin
          failures++;
          $display("FAIL beat_req cyc=%0d req=%b ready=%b required 1 0", c, ext_req, mem_ready);
        end
        checks++;
        if (ext_addr !== ea) begin
          failures++;
          $display("FAIL beat_addr cyc=%0d got=%h required=%h", c, ext_addr, ea);
        end
        checks++;
        if (ext_we !== rw) begin
          failures++;
          $display("FAIL beat_we cyc=%0d got=%b required=%b", c, ext_we, rw);
        end
        if (rw) begin
          checks++;
          if (ext_wdata !== wline[j*32 +: 32]) begin
            failures++;
            $display("FAIL beat_wdata cyc=%0d got=%h required=%h", c, ext_wdata, wline[j*32 +: 32]);
          end
        end
        if (j != abort_beat && c == bstart[j] + wt[j]) begin
          ext_ack   = 1'b1;
          ext_rdata = rdat[j];
          if (!rw) exp_rd[j*32 +: 32] = rdat[j];
        end
      end else begin
        checks++;
        if (mem_ready !== 1'b1 || ext_req !== 1'b0) begin
          failures++;
          $display("FAIL done_ready cyc=%0d ready=%b req=%b required 1 0", c, mem_ready, ext_req);
        end
        checks++;
        if (mem_err !== (abort_beat >= 0)) begin
          failures++;
          $display("FAIL done_err got=%b required=%b", mem_err, (abort_beat >= 0));
        end
        checks++;
        if (mem_rd !== exp_rd) begin
          failures++;
          $display("FAIL done_mem_rd got=%h required=%h", mem_rd, exp_rd);
        end
        ext_ack = 1'($urandom_range(1, 0));
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (mem_ready !== 1'b0 || mem_err !== 1'b0 || ext_req !== 1'b0 || ext_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b err=%b req=%b we=%b required 0", mem_ready, mem_err, ext_req, ext_we);
    end
    checks++;
    if (mem_rd !== '0 || ext_addr !== '0 || ext_wdata !== '0) begin
      failures++;
      $display("FAIL reset_data rd=%h addr=%h wdata=%h required 0", mem_rd, ext_addr, ext_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_zero_wait_read();
    logic [255:0] want;
    for (int k = 0; k < 8; k++) begin
      wt[k]   = 0;
      rdat[k] = 32'h1000_0000 + k;
      want[k*32 +: 32] = 32'h1000_0000 + k;
    end
    run_txn(1'b0, 28'h0ABC_DE5, rand_line(), 1'b0);
    checks++;
    if (mem_rd !== want) begin
      failures++;
      $display("FAIL zero_wait_line got=%h required=%h", mem_rd, want);
    end
    idle(2);
  endtask

  task automatic test_write_waits();
    logic [255:0] wl;
    for (int k = 0; k < 8; k++) begin
      wt[k] = 2;
      wl[k*32 +: 32] = 32'hA5A5_0000 + k;
    end
    run_txn(1'b1, 28'h0123_456, wl, 1'b1);
    idle(2);
  endtask

  task automatic test_timeout();
    set_waits(0, 1);
    wt[3] = 1000;
    run_txn(1'b0, $urandom, rand_line(), 1'b0);
    idle(3);
    set_waits(0, 1);
    wt[1] = 255;
    run_txn(1'b1, $urandom, rand_line(), 1'b0);
    idle(2);
  endtask

  task automatic test_ack_at_limit();
    set_waits(0, 1);
    wt[5] = 254;
    run_txn(1'b0, $urandom, rand_line(), 1'b0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    set_waits(0, 2);
    run_txn(1'b0, $urandom, rand_line(), 1'b0);
    set_waits(0, 2);
    run_txn(1'b1, $urandom, rand_line(), 1'b1);
    set_waits(0, 0);
    run_txn(1'b0, $urandom, rand_line(), 1'b0);
    idle(2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      set_waits(0, 3);
      run_txn(1'($urandom_range(1, 0)), $urandom, rand_line(), 1'($urandom_range(1, 0)));
      idle($urandom_range(2, 0));
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_valid = 1'b1;
    mem_rw    = 1'b0;
    mem_addr  = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      ext_ack   = 1'b1;
      ext_rdata = $urandom | 32'h1;
    end
    checks++;
    if (ext_req !== 1'b1 || ext_addr[2:0] !== 3'd5) begin
      failures++;
      $display("FAIL reset_mid_pre req=%b beat=%0d required 1 5", ext_req, ext_addr[2:0]);
    end
    #2 rst = 1'b1;
    #1;
    exp_rd = '0;
    checks++;
    if (ext_req !== 1'b0 || mem_ready !== 1'b0 || mem_rd !== '0) begin
      failures++;
      $display("FAIL reset_mid_async req=%b ready=%b rd=%h required 0 0 0", ext_req, mem_ready, mem_rd);
    end
    mem_valid = 1'b0;
    ext_ack   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(12);
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_timeout();
    test_ack_at_limit();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
